count_seq_decoder: RTL

// Receive-side decoder for the 3-bit count stream produced by the ROM-driven

---
 rtl/count_seq_if.sv | 21 ++
 rtl/count_seq_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/count_seq_if.sv
// Sample stream into the count-sequence decoder and its lock/status outputs.
interface count_seq_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic [2:0]       count;
    logic [1:0]       mode;
    logic             locked;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, count,
        input  mode, locked, mismatch, err_cnt
    );

    modport slave (
        input  en, count,
        output mode, locked, mismatch, err_cnt
    );
endinterface

// File: rtl/count_seq_decoder.sv
// Identifies which of four counting modes produces an incoming 3-bit stream,
// locks onto it and flags every step that breaks the locked sequence.
//
// state  | meaning
// IDLE   | waiting for the first sample after reset; it only seeds prev
// SEARCH | narrowing the candidate mode set until one survives LOCK_LEN steps
// LOCKED | mode known; each sample is checked against that mode's prediction
module count_seq_decoder #(
    parameter int LOCK_LEN = 4,
    parameter int MISS_MAX = 2,
    parameter int ERR_W    = 8
) (
    input logic         clk,
    input logic         res,
    count_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [2:0]       prev_q, prev_n;
    logic [3:0]       cand_q, cand_n;
    logic [3:0]       run_q, run_n;
    logic [3:0]       miss_q, miss_n;
    logic [1:0]       mode_q, mode_n;
    logic             locked_q, locked_n;
    logic             mismatch_q, mismatch_n;
    logic [ERR_W-1:0] err_q, err_n;

    logic [2:0]       pred0, pred1, pred2, pred3;
    logic [3:0]       match;
    logic [3:0]       cand_hit;

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Predictions for each mode from the previous sample, all mod 8.
    always_comb begin
        pred0    = prev_q + 3'd1;
        pred1    = prev_q - 3'd1;
        pred2    = prev_q + 3'd2;
        pred3    = bin2gray(gray2bin(prev_q) + 3'd1);
        match    = {bus.count == pred3, bus.count == pred2,
                    bus.count == pred1, bus.count == pred0};
        cand_hit = cand_q & match;
    end

    // State register and the registered datapath it sequences.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= IDLE;
            prev_q     <= 3'd0;
            cand_q     <= 4'b1111;
            run_q      <= 4'd0;
            miss_q     <= 4'd0;
            mode_q     <= 2'd0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_n;
            prev_q     <= prev_n;
            cand_q     <= cand_n;
            run_q      <= run_n;
            miss_q     <= miss_n;
            mode_q     <= mode_n;
            locked_q   <= locked_n;
            mismatch_q <= mismatch_n;
            err_q      <= err_n;
        end
    end

    // Next-state: everything holds on en=0 except the mismatch pulse.
    always_comb begin
        state_n    = state_q;
        prev_n     = prev_q;
        cand_n     = cand_q;
        run_n      = run_q;
        miss_n     = miss_q;
        mode_n     = mode_q;
        locked_n   = locked_q;
        mismatch_n = 1'b0;
        err_n      = err_q;

        if (bus.en) begin
            prev_n = bus.count;
            case (state_q)
                IDLE: begin
                    state_n = SEARCH;
                end

                SEARCH: begin
                    if (cand_hit != 4'b0000) begin
                        cand_n = cand_hit;
                        run_n  = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;
                    end else if (match != 4'b0000) begin
                        cand_n = match;
                        run_n  = 4'd1;
                    end else begin
                        cand_n = 4'b1111;
                        run_n  = 4'd0;
                    end
                    // Ambiguous candidate sets keep searching rather than guess.
                    if ($onehot(cand_n) && (int'(run_n) >= LOCK_LEN)) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                        mode_n   = onehot_idx(cand_n);
                        miss_n   = 4'd0;
                    end
                end

                LOCKED: begin
                    if (match[mode_q]) begin
                        miss_n = 4'd0;
                    end else begin
                        mismatch_n = 1'b1;
                        if (err_q != {ERR_W{1'b1}})
                            err_n = err_q + 1'b1;
                        miss_n = miss_q + 4'd1;
                        if (int'(miss_q) + 1 == MISS_MAX) begin
                            state_n  = SEARCH;
                            locked_n = 1'b0;
                            cand_n   = 4'b1111;
                            run_n    = 4'd0;
                        end
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.mode     = mode_q;
        bus.locked   = locked_q;
        bus.mismatch = mismatch_q;
        bus.err_cnt  = err_q;
    end

endmodule
